// File: rtl/hp_bar_draw_if.sv
// Pixel-drawer handshake bundle: start/value request plus done and drawEn/x/y/colour pixel stream.
// The drawer uses the slave modport. The requester (game control, or the bench) uses master.
interface hp_bar_draw_if #(
    parameter int VAL_W   = 5,
    parameter int COLOR_W = 3
);
    logic               start;
    logic [VAL_W-1:0]   value;
    logic               done;
    logic               drawEn;
    logic [7:0]         x;
    logic [6:0]         y;
    logic [COLOR_W-1:0] colour;

    modport master (
        output start, value,
        input  done, drawEn, x, y, colour
    );

    modport slave (
        input  start, value,
        output done, drawEn, x, y, colour
    );
endinterface

// File: rtl/hp_bar_draw.sv
// HP bar drawer: paints a MAX_LEN x HEIGHT bar column-major, filled up to min(value, MAX_LEN).
// Define BAR_BORDER_EN to paint the outer ring of the bar in BORDER_COLOR.
module hp_bar_draw #(
    parameter int X0      = 131,
    parameter int Y0      = 111,
    parameter int MAX_LEN = 18,
    parameter int HEIGHT  = 4,
    parameter int VAL_W   = 5,
    parameter int COLOR_W = 3,
    parameter logic [COLOR_W-1:0] FILL_COLOR  = 3'b010,
    parameter logic [COLOR_W-1:0] EMPTY_COLOR = 3'b100
`ifdef BAR_BORDER_EN
    , parameter logic [COLOR_W-1:0] BORDER_COLOR = 3'b111
`endif
) (
    input  logic           clk,
    input  logic           reset,
    hp_bar_draw_if.slave   bus
);
    localparam int COL_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t             r_state, w_state_next;
    logic [COL_W-1:0]   r_col, w_col_next;
    logic [ROW_W-1:0]   r_row, w_row_next;
    logic [LEN_W-1:0]   r_len_q, w_len_next;
    logic               r_done, w_done_next;
    logic               r_draw, w_draw_next;
    logic [7:0]         r_x, w_x_next;
    logic [6:0]         r_y, w_y_next;
    logic [COLOR_W-1:0] r_colour, w_colour_next;
    logic [VAL_W-1:0]   w_value;
    logic               w_last;

    assign w_value = bus.value;
    assign w_last  = (32'(r_col) == 32'(MAX_LEN - 1)) && (32'(r_row) == 32'(HEIGHT - 1));

    // Outputs are registered, so next-cycle pixel values are computed from the next counters.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        w_state_next  = r_state;
        w_col_next    = r_col;
        w_row_next    = r_row;
        w_len_next    = r_len_q;
        w_done_next   = 1'b0;
        w_draw_next   = 1'b0;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_colour_next = r_colour;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_len_next   = (32'(w_value) > 32'(MAX_LEN)) ? LEN_W'(MAX_LEN) : LEN_W'(w_value);
                    w_col_next   = '0;
                    w_row_next   = '0;
                    w_draw_next  = 1'b1;
                    w_state_next = S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_last) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_draw_next = 1'b1;
                    if (32'(r_row) == 32'(HEIGHT - 1)) begin
                        w_row_next = '0;
                        w_col_next = r_col + COL_W'(1);
                    end else begin
                        w_row_next = r_row + ROW_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (bus.start) w_done_next  = 1'b1;
                else           w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_draw_next) begin
            w_x_next = 8'(X0 + 32'(w_col_next));
            w_y_next = 7'(Y0 + 32'(w_row_next));
            w_colour_next = (32'(w_col_next) < 32'(w_len_next)) ? FILL_COLOR : EMPTY_COLOR;
`ifdef BAR_BORDER_EN
            if (w_row_next == '0 || 32'(w_row_next) == 32'(HEIGHT - 1) ||
                w_col_next == '0 || 32'(w_col_next) == 32'(MAX_LEN - 1))
                w_colour_next = BORDER_COLOR;
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state  <= S_IDLE;
            r_col    <= '0;
            r_row    <= '0;
            r_len_q  <= '0;
            r_done   <= 1'b0;
            r_draw   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
        end else begin
            r_state  <= w_state_next;
            r_col    <= w_col_next;
            r_row    <= w_row_next;
            r_len_q  <= w_len_next;
            r_done   <= w_done_next;
            r_draw   <= w_draw_next;
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_colour <= w_colour_next;
        end
    end

    assign bus.done   = r_done;
    assign bus.drawEn = r_draw;
    assign bus.x      = r_x;
    assign bus.y      = r_y;
    assign bus.colour = r_colour;
endmodule

// File: tb/tb_hp_bar_draw.sv
// Directed bench for hp_bar_draw: full-bar scans with clamping, latching, reset and done-hold cases.
// Expected pixels come from a column-major model of the 18x4 bar at (131,111).
module tb_hp_bar_draw;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hp_bar_draw_if #(.VAL_W(5), .COLOR_W(3)) bus ();

    hp_bar_draw dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_colour(input int col, input int row, input int len);
`ifdef BAR_BORDER_EN
        if (row == 0 || row == 3 || col == 0 || col == 17) return 3'b111;
`endif
        return (col < len) ? 3'b010 : 3'b100;
    endfunction

    // Runs one full bar; value changes at chg_idx and start drops at drop_idx (-1 = never).
    task automatic draw_bar(input int val, input int exp_len, input int chg_idx,
                            input int chg_val, input int drop_idx);
        logic [31:0] exp_pix;
        bus.value = 5'(val);
        bus.start = 1'b1;
        for (int k = 0; k < 72; k++) begin
            @(negedge clk);
            exp_pix = {13'd0, 1'b1, 8'(131 + k / 4), 7'(111 + k % 4), exp_colour(k / 4, k % 4, exp_len)};
            check($sformatf("pix%0d_v%0d", k, val),
                  {13'd0, bus.drawEn, bus.x, bus.y, bus.colour}, exp_pix);
            if (k == chg_idx)  bus.value = 5'(chg_val);
            if (k == drop_idx) bus.start = 1'b0;
        end
        @(negedge clk);
        check($sformatf("done_after_v%0d", val), {30'd0, bus.done, bus.drawEn}, {30'd0, 2'b10});
    endtask

    task automatic release_start();
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_after_release", {30'd0, bus.done, bus.drawEn}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.value = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {13'd0, bus.done, bus.drawEn, bus.x, bus.y, bus.colour}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_draw", {30'd0, bus.done, bus.drawEn}, 32'd0);

        // value=5, then start held 10 cycles after done
        draw_bar(5, 5, -1, 0, -1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("done_hold%0d", i), {30'd0, bus.done, bus.drawEn}, {30'd0, 2'b10});
        end
        release_start();
        @(negedge clk);
        check("stay_idle", {30'd0, bus.done, bus.drawEn}, 32'd0);

        // empty and clamped-full bars
        draw_bar(0, 0, -1, 0, -1);
        release_start();
        draw_bar(25, 18, -1, 0, -1);
        release_start();

        // value latched at start, later change ignored
        draw_bar(10, 10, 20, 2, -1);
        release_start();

        // start dropped mid-draw: finishes, one done cycle, back to idle
        draw_bar(3, 3, -1, 0, 5);
        @(negedge clk);
        check("drop_done_one_cycle", {30'd0, bus.done, bus.drawEn}, 32'd0);

        // reset at pixel 30
        bus.value = 5'd7;
        bus.start = 1'b1;
        repeat (31) @(negedge clk);
        check("pix30_pos", {16'd0, bus.drawEn, bus.x, bus.y}, {16'd0, 1'b1, 8'd138, 7'd113});
        reset     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("reset_mid_draw", {13'd0, bus.done, bus.drawEn, bus.x, bus.y, bus.colour}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        draw_bar(18, 18, -1, 0, -1);
        release_start();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hp_bar_draw.md
Name: hp_bar_draw

Overview:
Parametrised successor of the player HP bar drawer. Renders a complete fixed-size bar into the VGA framebuffer: a filled section proportional to an input value, plus an explicitly drawn empty remainder, so the bar shrinks correctly without a separate clear pass. Sits between the game-control FSM and the VGA adapter. Uses the same start/done handshake and drawEn/x/y pixel interface as the other draw blocks, plus a colour output.

Parameters:
X0, 131, x coordinate of bar left column
Y0, 111, y coordinate of bar top row
MAX_LEN, 18, bar length in pixels (columns), 1..(160-X0)
HEIGHT, 4, bar height in pixels (rows), 1..(120-Y0)
VAL_W, 5, width of value input
COLOR_W, 3, colour width
FILL_COLOR, 3'b010, colour of filled columns
EMPTY_COLOR, 3'b100, colour of empty columns
BORDER_COLOR, 3'b111, border colour (used only with BAR_BORDER_EN)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  level request to draw; must stay high until done seen
value  input  VAL_W  bar fill length in pixels (e.g. HP)
done  output  1  high while in DONE state
drawEn  output  1  pixel write enable to VGA adapter
x  output  8  pixel x
y  output  7  pixel y
colour  output  COLOR_W  pixel colour

Behaviour:
- One clock (clk); reset synchronous, active-high. All outputs registered.
- Reset values: done=0, drawEn=0, x=0, y=0, colour=0, state=IDLE, col=0, row=0, len_q=0.
- States: IDLE, DRAW, DONE.
- IDLE: drawEn=0, done=0. When start=1, latch len_q = min(value, MAX_LEN); col=0, row=0; go to DRAW.
- DRAW: one pixel per cycle, drawEn=1, x=X0+col, y=Y0+row, colour = (col < len_q) ? FILL_COLOR : EMPTY_COLOR.
- Scan order: row 0..HEIGHT-1 within a column, then next column (column-major, as in the existing drawer).
- First pixel is presented on the cycle after start is sampled in IDLE. Exactly MAX_LEN*HEIGHT consecutive drawEn=1 cycles, with no gaps.
- After the pixel (col=MAX_LEN-1, row=HEIGHT-1), go to DONE. drawEn=0 and done=1 from the next cycle.
- DONE: hold done=1 and drawEn=0 while start=1. When start=0, done=0 and return to IDLE; done deasserts in the same cycle IDLE is entered. No retrigger without start dropping first.
- value is sampled only on IDLE->DRAW; changes during DRAW or DONE are ignored.
- value=0: all columns EMPTY_COLOR. value>=MAX_LEN: all columns FILL_COLOR (clamped, no wrap).
- Counter widths: col sized to hold MAX_LEN-1 and row to hold HEIGHT-1. x/y sums are computed at full width, then truncated to 8/7 bits. Parameter legality guarantees no overflow.
- start dropped during DRAW: drawing completes. The block passes through DONE for one cycle with done=1, then returns to IDLE.
- reset during DRAW or DONE: next cycle is IDLE with all outputs at reset values. The partially drawn bar is left as is.

Optional Feature:
BAR_BORDER_EN:
- Defined: pixels with row==0, row==HEIGHT-1, col==0 or col==MAX_LEN-1 use BORDER_COLOR. Interior pixels use the fill/empty rule. len_q comparison and pixel count are unchanged.
- Undefined: no border logic; every pixel follows the fill/empty rule and BORDER_COLOR is unused.

Test Plan:
- Defaults, value=5, start held -> 72 drawEn cycles, x 131..148, y 111..114 column-major. x 131..135 FILL_COLOR, x 136..148 EMPTY_COLOR. done=1 the cycle after the last pixel.
- value=0, then value=25 -> all 72 pixels EMPTY_COLOR, then all 72 pixels FILL_COLOR (clamped); pixel count unchanged in both runs.
- value=10 latched, value changed to 2 at pixel 20 -> colouring still uses 10: x 131..140 FILL_COLOR.
- reset asserted at pixel 30 -> next cycle drawEn=0, done=0, x=0, y=0. A new start restarts from (131,111).
- start held 10 cycles after done -> done stays 1, drawEn stays 0. start low -> done=0 next cycle, block back in IDLE.
- BAR_BORDER_EN defined, value=18 -> rows 111/114 and columns 131/148 BORDER_COLOR, interior FILL_COLOR.
